// File: rtl/mux_rr_scheduler.sv
// -----------------------------------------------------------------------------
// mux_rr_scheduler
//
// Round-robin scheduler for eight requesters that drives the select of an
// 8:1 data multiplexer. A source keeps its grant until it drops its request
// line or has held the grant for HOLD consecutive cycles. When a grant ends,
// the next winner is chosen in the same cycle, starting the search just
// after the releasing source. A source that is still requesting is therefore
// re-granted only when nobody else is waiting, and there is no idle cycle
// between back-to-back grants.
//
// Parameters
//   HOLD  maximum consecutive cycles of one grant (1..15)
//
// Ports
//   clk   input   1  single clock, rising edge
//   rst   input   1  synchronous, active-high reset
//   req   input   8  request line per source, held high until served
//   in    input   8  data bit per source
//   sel   output  3  registered index of the granted source
//   gnt   output  8  registered one-hot grant, zero when idle
//   busy  output 1   high while a grant is active
//   out   output 1   registered data bit of the granted source, 0 when idle
// -----------------------------------------------------------------------------
module mux_rr_scheduler #(
  parameter int HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic [7:0] in,
  output logic [2:0] sel,
  output logic [7:0] gnt,
  output logic       busy,
  output logic       out
);

  localparam logic [3:0] HOLD_CNT = 4'(HOLD);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] ptr_q,   ptr_d;
  logic [3:0] cnt_q,   cnt_d;
  logic [2:0] sel_q,   sel_d;
  logic [7:0] gnt_q,   gnt_d;
  logic       busy_q,  busy_d;
  logic       out_q,   out_d;

  // Arbiter signals
  logic [2:0] search_base;
  logic [2:0] idx;
  logic [2:0] winner;
  logic       found;
  logic       rel_grant;

  // ---------------------------------------------------------------------------
  // Rotating priority search.
  // In IDLE the search starts at ptr. In GRANT the only arbitration happens at
  // release, and ptr becomes sel+1 in that same cycle, so the search starts at
  // sel+1 directly. The releasing source sits at offset 7 and so ranks lowest.
  // The loop runs from the farthest offset down to offset 0, so the nearest
  // requester is the last assignment and wins.
  // ---------------------------------------------------------------------------
  always_comb begin
    search_base = (state_q == GRANT) ? (sel_q + 3'd1) : ptr_q;
    idx         = search_base;
    winner      = search_base;
    found       = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      idx = search_base + 3'(i);
      if (req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  // A grant ends when its requester drops or the hold limit is reached. Both
  // conditions feed the same single release.
  assign rel_grant = (state_q == GRANT) && (!req[sel_q] || (cnt_q == HOLD_CNT));

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first. A path that leaves
  // a signal unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    busy_d  = busy_q;

    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          sel_d   = winner;
          gnt_d   = 8'd1 << winner;
          busy_d  = 1'b1;
          cnt_d   = 4'd1;
        end else begin
          gnt_d  = 8'd0;
          busy_d = 1'b0;
        end
      end

      GRANT: begin
        if (rel_grant) begin
          ptr_d = sel_q + 3'd1;
          if (found) begin
            // Hand over directly, with no idle bubble.
            sel_d  = winner;
            gnt_d  = 8'd1 << winner;
            busy_d = 1'b1;
            cnt_d  = 4'd1;
          end else begin
            state_d = IDLE;
            gnt_d   = 8'd0;
            busy_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      default: begin
        state_d = IDLE;
        gnt_d   = 8'd0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // The data path uses the registered select, so out trails sel/in by one
  // cycle and reads 0 whenever no grant is active.
  assign out_d = busy_q ? in[sel_q] : 1'b0;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: non-blocking assignments let every register sample the same
  // pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 3'd0;
      cnt_q   <= 4'd0;
      sel_q   <= 3'd0;
      gnt_q   <= 8'd0;
      busy_q  <= 1'b0;
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      out_q   <= out_d;
    end
  end

  assign sel  = sel_q;
  assign gnt  = gnt_q;
  assign busy = busy_q;
  assign out  = out_q;

endmodule

// File: doc/mux_rr_scheduler.md
MUX_RR_SCHEDULER -- requirements
Module: mux_rr_scheduler

Interface
REQ-001 SHALL have parameter HOLD, default 4, meaning the maximum consecutive cycles of one grant (legal range 1..15).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; it is synchronous and active-high.
REQ-004 SHALL have port req, input, 8, one request line per source; a requester holds it high until served.
REQ-005 SHALL have port in, input, 8, one data bit per source.
REQ-006 SHALL have port sel, output, 3, the registered index of the granted source, driving the 8:1 select.
REQ-007 SHALL have port gnt, output, 8, the registered one-hot grant, all-zero when idle.
REQ-008 SHALL have port busy, output, 1, high while any grant is active.
REQ-009 SHALL have port out, output, 1, the registered selected data bit.

Function
REQ-010 SHALL implement two states: IDLE and GRANT.
REQ-011 SHALL keep a 3-bit round-robin pointer ptr and a 4-bit hold counter cnt.
REQ-012 SHALL pick the winner as the first index with req high, searching ascending from ptr and wrapping 7->0.
REQ-013 In IDLE with req != 0, SHALL load sel=winner, gnt=1<<winner, busy=1, cnt=1 and enter GRANT at the next edge.
REQ-014 In IDLE with req == 0, SHALL hold gnt=0, busy=0 and keep sel unchanged.
REQ-015 In GRANT, SHALL release when req[sel]==0 or cnt==HOLD is sampled; otherwise it SHALL increment cnt and hold sel and gnt.
REQ-016 When release and the HOLD limit coincide, SHALL perform exactly one release.
REQ-017 On release, SHALL set ptr=sel+1 mod 8, wrapping 7->0.
REQ-018 On release, SHALL re-arbitrate in the same cycle using the updated ptr over the current req; the releasing source is eligible only at lowest priority.
REQ-019 On release, if a winner exists, SHALL grant it at the next edge (cnt=1, stay GRANT) with no idle bubble; otherwise SHALL go to IDLE with gnt=0 and busy=0.
REQ-020 SHALL keep gnt one-hot or zero at all times, and gnt SHALL equal 1<<sel whenever busy=1.
REQ-021 SHALL register out as in[sel] when busy=1 and as 0 when busy=0, giving one cycle of latency from sel/in to out.
REQ-022 SHALL ignore changes on req bits of non-granted sources during GRANT until the next arbitration.

Reset
REQ-023 With rst=1 at an edge, SHALL set state=IDLE, ptr=0, cnt=0, sel=0, gnt=0, busy=0 and out=0, overriding all other activity, including mid-grant.
REQ-024 The first arbitration after reset SHALL search from index 0.

Verification
REQ-025 Reset then req=8'h81 held, HOLD=4 -> gnt=8'h01, sel=0 for 4 cycles, then gnt=8'h80, sel=7 for 4 cycles, then gnt=8'h01 again (ptr wrap).
REQ-026 req=8'hFF held -> grants to 0,1,...,7,0 in order, each exactly HOLD cycles, busy continuously 1, no zero-gnt cycle.
REQ-027 req[3] high for 2 cycles only -> gnt=8'h08 for 2 cycles starting one cycle after req rises, then gnt=0 and busy=0.
REQ-028 Source 5 granted, in=8'h20 -> out=1 one cycle after sel=5; in then set to 8'h00 -> out=0 on the following cycle; after idle, out=0.
REQ-029 rst pulsed during a grant to source 6 -> next cycle gnt=0, busy=0, sel=0, out=0; then req=8'h50 -> source 4 is granted first.
REQ-030 Only req[2] held continuously, HOLD=4 -> source 2 is re-granted back-to-back every 4 cycles, gnt stays 8'h04 and busy stays 1 throughout.
